// File: rtl/regs_arbiter.sv
// rtl/regs_arbiter.sv - two-requester arbiter for the PWM register-file bus
// Optional round-robin tie-break under REGS_ARB_RR_EN (fixed m0 priority otherwise).
module regs_arbiter #(
  parameter int                ADDR_W   = 6,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 6'h0D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_write,
  input  logic [DATA_W-1:0] data_read,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [2:0] {IDLE, WR, RD1, RD2, ACK} state_t;

  // Counter-value register: readable, but writes are refused.
  localparam logic [ADDR_W-1:0] RO_ADDR = ADDR_W'(8);

  state_t              state, state_n;
  logic                read_n, write_n, busy_n, owner_n;
  logic                m0_ack_n, m0_err_n, m1_ack_n, m1_err_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DATA_W-1:0]   data_write_n, m0_rdata_n, m1_rdata_n;

  logic                any_req, win, sel_we, reject;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  assign any_req = m0_req | m1_req;

`ifdef REGS_ARB_RR_EN
  logic last_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_grant <= 1'b1;
    else if (state == IDLE && any_req)
      last_grant <= win;
  end

  assign win = (m0_req && m1_req) ? ~last_grant : m1_req;
`else
  assign win = ~m0_req;
`endif

  assign sel_we    = win ? m1_we    : m0_we;
  assign sel_addr  = win ? m1_addr  : m0_addr;
  assign sel_wdata = win ? m1_wdata : m0_wdata;
  assign reject    = (sel_addr > MAX_ADDR) || (sel_we && sel_addr == RO_ADDR);

  always_comb begin
    state_n      = state;
    read_n       = 1'b0;
    write_n      = 1'b0;
    m0_ack_n     = 1'b0;
    m0_err_n     = 1'b0;
    m1_ack_n     = 1'b0;
    m1_err_n     = 1'b0;
    addr_n       = addr;
    data_write_n = data_write;
    owner_n      = owner;
    m0_rdata_n   = m0_rdata;
    m1_rdata_n   = m1_rdata;
    case (state)
      IDLE: begin
        if (any_req) begin
          owner_n      = win;
          addr_n       = sel_addr;
          data_write_n = sel_wdata;
          if (reject) begin
            state_n = ACK;
            if (win) begin
              m1_ack_n = 1'b1;
              m1_err_n = 1'b1;
              if (!sel_we) m1_rdata_n = '0;
            end else begin
              m0_ack_n = 1'b1;
              m0_err_n = 1'b1;
              if (!sel_we) m0_rdata_n = '0;
            end
          end else if (sel_we) begin
            state_n = WR;
            write_n = 1'b1;
          end else begin
            state_n = RD1;
            read_n  = 1'b1;
          end
        end
      end
      WR: begin
        state_n  = ACK;
        m0_ack_n = ~owner;
        m1_ack_n = owner;
      end
      RD1: begin
        state_n = RD2;
        read_n  = 1'b1;
      end
      RD2: begin
        // Register file's buffered data is valid during this cycle.
        state_n  = ACK;
        m0_ack_n = ~owner;
        m1_ack_n = owner;
        if (owner) m1_rdata_n = data_read;
        else       m0_rdata_n = data_read;
      end
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      read       <= 1'b0;
      write      <= 1'b0;
      busy       <= 1'b0;
      owner      <= 1'b0;
      m0_ack     <= 1'b0;
      m0_err     <= 1'b0;
      m1_ack     <= 1'b0;
      m1_err     <= 1'b0;
      addr       <= '0;
      data_write <= '0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      state      <= state_n;
      read       <= read_n;
      write      <= write_n;
      busy       <= busy_n;
      owner      <= owner_n;
      m0_ack     <= m0_ack_n;
      m0_err     <= m0_err_n;
      m1_ack     <= m1_ack_n;
      m1_err     <= m1_err_n;
      addr       <= addr_n;
      data_write <= data_write_n;
      m0_rdata   <= m0_rdata_n;
      m1_rdata   <= m1_rdata_n;
    end
  end

endmodule
